// File: rtl/riscv_tag_check_logic.sv
// DIFT tag check unit: raises a security exception when a tainted operand reaches an enabled use point.
// Optional macro DIFT_TAG_CHECK_PC_CAPTURE_EN adds capture of the violating PC on exc_pc_o.
module riscv_tag_check_logic #(
   parameter int CNT_WIDTH = 16,
   parameter int PC_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 check_valid_i,
   input  logic [2:0]           check_class_i,
   input  logic                 tag_a_i,
   input  logic                 tag_b_i,
   input  logic [PC_WIDTH-1:0]  pc_i,
   input  logic [5:0]           tcr_i,
   input  logic                 exc_ack_i,
   input  logic                 cnt_clear_i,
   output logic                 exc_req_o,
   output logic [2:0]           exc_cause_o,
   output logic [PC_WIDTH-1:0]  exc_pc_o,
   output logic                 halt_o,
   output logic [CNT_WIDTH-1:0] violation_cnt_o
);
   // state   | meaning
   // IDLE    | no exception outstanding, violations are accepted
   // PENDING | exception requested, pipeline halted, waiting for ack
   typedef enum logic {ST_IDLE, ST_PENDING} state_e;

   state_e               state_q, state_d;
   logic [2:0]           cause_q, cause_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 class_en;
   logic                 tainted;
   logic                 violation;
   logic                 accept;

   always_comb begin
      class_en = 1'b0;
      tainted  = 1'b0;
      case (check_class_i)
         3'd0: begin class_en = tcr_i[0]; tainted = tag_a_i; end
         3'd1: begin class_en = tcr_i[1]; tainted = tag_a_i; end
         3'd2: begin class_en = tcr_i[2]; tainted = tag_a_i | tag_b_i; end
         3'd3: begin class_en = tcr_i[3]; tainted = tag_a_i; end
         3'd4: begin class_en = tcr_i[4]; tainted = tag_a_i; end
         3'd5: begin class_en = tcr_i[5]; tainted = tag_b_i; end
         default: begin class_en = 1'b0; tainted = 1'b0; end
      endcase
   end

   assign violation = check_valid_i & class_en & tainted;
   // Only violations seen in IDLE are latched and counted; the rest are dropped.
   assign accept    = (state_q == ST_IDLE) & violation;

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_PENDING;
               cause_d = check_class_i;
            end
         end
         ST_PENDING: begin
            if (exc_ack_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (cnt_clear_i) begin
         cnt_d = '0;
      end else if (accept && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cause_q <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef DIFT_TAG_CHECK_PC_CAPTURE_EN
   logic [PC_WIDTH-1:0] pc_q, pc_d;

   assign pc_d = accept ? pc_i : pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign exc_pc_o = pc_q;
`else
   logic unused_pc;
   assign unused_pc = ^pc_i;
   assign exc_pc_o  = '0;
`endif

   assign exc_req_o       = (state_q == ST_PENDING);
   assign halt_o          = (state_q == ST_PENDING);
   assign exc_cause_o     = cause_q;
   assign violation_cnt_o = cnt_q;

endmodule
